// File: rtl/wrr_hold_arbiter.sv
// wrr_hold_arbiter: weighted round-robin arbiter for 4 requesters. Each grant
// is held until the owner signals done, drops its request, or times out.
// The optional hold timeout is compiled in with `define WRR_HOLD_TIMEOUT_EN.
module wrr_hold_arbiter #(
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            done,
  input  logic [4*WEIGHT_W-1:0] weight,
  input  logic                  cfg_load,
  output logic [3:0]            gnt,
  output logic [1:0]            gnt_id,
  output logic                  busy,
  output logic                  timeout_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wrr_hold_arbiter: TIMEOUT must be in 2..255");
  end

  state_e              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          gnt_id_q, gnt_id_d;
  logic                busy_q, busy_d;
  logic                timeout_pulse_q, timeout_pulse_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] weight_q [4];
  logic [WEIGHT_W-1:0] weight_d [4];
  logic [WEIGHT_W-1:0] credit_q [4];
  logic [WEIGHT_W-1:0] credit_d [4];

  logic [WEIGHT_W-1:0] credit_eff [4];
  logic [3:0]          raw_elig;
  logic [3:0]          elig;
  logic                refill;
  logic                win_found;
  logic [1:0]          win_id;
  logic                owner_done;
  logic                owner_abandon;
  logic                timeout_hit;
  logic                release_evt;
  logic [WEIGHT_W-1:0] credit_dec;

  // Weight registers: captured on cfg_load in any state; a zero weight is stored as one.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      weight_d[i] = weight_q[i];
      if (cfg_load) begin
        weight_d[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? ONE
                                                              : weight[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // Eligibility, with same-cycle refill when requests exist but none has credit.
  always_comb begin
    raw_elig = '0;
    elig     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      raw_elig[i] = req[i] && (credit_q[i] != '0);
    end
    refill = (req != '0) && (raw_elig == '0);
    for (int unsigned i = 0; i < 4; i++) begin
      credit_eff[i] = refill ? weight_q[i] : credit_q[i];
      elig[i]       = req[i] && (credit_eff[i] != '0);
    end
  end

  // Round-robin pick: first eligible requester scanning from ptr with 2-bit wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!win_found && elig[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_id    = ptr_q + 2'(k);
      end
    end
  end

  // Release conditions seen while the current owner holds the grant.
  always_comb begin
    owner_done    = done[gnt_id_q];
    owner_abandon = !req[gnt_id_q];
    release_evt   = owner_done || owner_abandon || timeout_hit;
    credit_dec    = credit_q[gnt_id_q] - ONE;
  end

`ifdef WRR_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Hold counter: zero outside GRANT, counts cycles spent in GRANT.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == ST_GRANT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign timeout_hit = (state_q == ST_GRANT) && (hold_cnt_q == HOLD_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbitration FSM: next state, grant registers, credit and pointer updates.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_id_d        = gnt_id_q;
    busy_d          = busy_q;
    timeout_pulse_d = 1'b0;
    ptr_d           = ptr_q;
    credit_d        = credit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          credit_d = credit_eff;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          busy_d   = 1'b1;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_evt) begin
          gnt_d              = '0;
          busy_d             = 1'b0;
          credit_d[gnt_id_q] = credit_dec;
          ptr_d              = (credit_dec != '0) ? gnt_id_q : gnt_id_q + 2'd1;
          // A timeout only counts as forced when no normal release coincides.
          timeout_pulse_d    = timeout_hit && !owner_done && !owner_abandon;
          state_d            = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      gnt_q           <= '0;
      gnt_id_q        <= '0;
      busy_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
      ptr_q           <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        weight_q[i] <= ONE;
        credit_q[i] <= ONE;
      end
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_id_q        <= gnt_id_d;
      busy_q          <= busy_d;
      timeout_pulse_q <= timeout_pulse_d;
      ptr_q           <= ptr_d;
      weight_q        <= weight_d;
      credit_q        <= credit_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_id        = gnt_id_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// tb_wrr_hold_arbiter: directed bench for wrr_hold_arbiter. Expected grant
// owners are queued as stimulus is applied and popped as grants appear.
module tb_wrr_hold_arbiter;

  localparam int WEIGHT_W = 4;
  localparam int TIMEOUT  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [3:0]            req;
  logic [3:0]            done;
  logic [4*WEIGHT_W-1:0] weight;
  logic                  cfg_load;
  logic [3:0]            gnt;
  logic [1:0]            gnt_id;
  logic                  busy;
  logic                  timeout_pulse;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned exp_q[$];
  int unsigned hi;

  always #5 clk = ~clk;

  wrr_hold_arbiter #(
    .WEIGHT_W(WEIGHT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .weight       (weight),
    .cfg_load     (cfg_load),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  function automatic logic [3:0] onehot(input int unsigned id);
    logic [1:0] sel;
    sel = id[1:0];
    onehot = '0;
    onehot[sel] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pops the next expected owner, waits (bounded) for a grant, checks it.
  task automatic expect_grant(input int unsigned exp_idle);
    int unsigned id;
    int unsigned idle;
    id   = exp_q.pop_front();
    idle = 0;
    forever begin
      @(negedge clk);
      if (gnt !== 4'b0000) break;
      idle++;
      if (idle >= 30) break;
    end
    chk("grant_gap", idle, exp_idle);
    chk("gnt", gnt, onehot(id));
    chk("gnt_id", gnt_id, id);
    chk("busy_on", busy, 1);
  endtask

  task automatic ack_owner();
    done = gnt;
    @(negedge clk);
    done = '0;
    chk("rel_gnt", gnt, 0);
    chk("rel_busy", busy, 0);
    chk("rel_pulse", timeout_pulse, 0);
  endtask

  // Grant, hold one more cycle, then done: done is sampled two edges after the grant.
  task automatic serve(input int unsigned exp_idle);
    logic [3:0] held;
    expect_grant(exp_idle);
    held = gnt;
    @(negedge clk);
    chk("gnt_hold", gnt, held);
    ack_owner();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    done     = '0;
    weight   = '0;
    cfg_load = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", timeout_pulse, 0);
    rst_n = 1'b1;

    // Default weights, all requesting: plain rotation then refill back to 0.
    req = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    serve(0);
    repeat (4) serve(1);
    req = '0;

    // Requester 0 weight 3. Requester 1 still holds a credit from before.
    @(negedge clk);
    weight   = {4'd1, 4'd1, 4'd1, 4'd3};
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    req      = 4'b0011;
    exp_q.push_back(1);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    end
    serve(0);
    repeat (8) serve(1);
    req = '0;

    // Reset while requester 1 owns the grant.
    req = 4'b0010;
    exp_q.push_back(1);
    expect_grant(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_gnt", gnt, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_gnt_id", gnt_id, 0);
    chk("rstmid_pulse", timeout_pulse, 0);
    exp_q.push_back(1);
    serve(0);
    // Weights are back to 1: 0 and 1 alternate.
    req = 4'b0011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    repeat (4) serve(1);
    req = '0;

    // Fresh reset; owner 2 ignores done bits of non-owners, then abandons.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    exp_q.push_back(2);
    expect_grant(0);
    done = 4'b1011;
    repeat (4) begin
      @(negedge clk);
      chk("nonowner_done_gnt", gnt, 4'b0100);
      chk("nonowner_done_busy", busy, 1);
    end
    done = '0;
    req  = '0;
    @(negedge clk);
    chk("abandon_gnt", gnt, 0);
    chk("abandon_busy", busy, 0);
    chk("abandon_pulse", timeout_pulse, 0);
    // Credit of 2 is spent, so the pointer moved on to 3.
    req = 4'b1011;
    exp_q.push_back(3);
    expect_grant(1);
    ack_owner();

    // Request 2 with done never asserted.
    req = 4'b0100;
    exp_q.push_back(2);
    expect_grant(1);
`ifdef WRR_HOLD_TIMEOUT_EN
    hi = 1;
    forever begin
      @(negedge clk);
      if (gnt !== 4'b0100) break;
      hi++;
      if (hi > 100) break;
    end
    chk("timeout_len", hi, TIMEOUT);
    chk("timeout_gnt_off", gnt, 0);
    chk("timeout_pulse_on", timeout_pulse, 1);
    @(negedge clk);
    chk("timeout_pulse_off", timeout_pulse, 0);
    chk("timeout_release_gnt", gnt, 0);
    @(negedge clk);
    chk("timeout_regrant", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    chk("final_release_gnt", gnt, 0);
`else
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      hi++;
      chk("hold_forever_gnt", gnt, 4'b0100);
      chk("hold_forever_pulse", timeout_pulse, 0);
    end
    ack_owner();
    req = '0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
